freq_avg_bcd: RTL and testbench

Post-processing stage downstream of the frequency counter. It accepts each completed gate-window count (`in_vld`/`in_cnt`) and keeps a sliding-window average over the last 2^AVG_LOG2 counts. It converts that average to packed BCD with a sequential double-dabble engine and presents the result on a valid/ready output port for the display or reporting logic.

---
 rtl/freq_avg_bcd.sv | 206 ++++++++++++++++++++
 tb/tb_freq_avg_bcd.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_avg_bcd.sv
// freq_avg_bcd: sliding-window average of gate counts, converted to 5-digit packed BCD.
// Latency: in_vld in cycle T -> out_vld in T+CNT_W+2; one sample in flight at a time.
// Backpressure: result held in HOLD until out_ready; strobes arriving while busy are dropped with a drop pulse.
// Optional: define FREQ_MINMAX_EN to add out_min/out_max tracking of the raw accepted samples.
module freq_avg_bcd #(
  parameter int CNT_W    = 16,
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_vld,
  input  logic [CNT_W-1:0] in_cnt,
  output logic             out_vld,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_avg,
  output logic [19:0]      out_bcd,
`ifdef FREQ_MINMAX_EN
  output logic [CNT_W-1:0] out_min,
  output logic [CNT_W-1:0] out_max,
`endif
  output logic             busy,
  output logic             drop
);
  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = CNT_W + AVG_LOG2;
  localparam int WP_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int STEP_W = $clog2(CNT_W + 1);

  typedef enum logic [1:0] {IDLE, ACC, CONV, HOLD} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  sample_q, sample_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [WP_W-1:0]   wp_q, wp_d;
  logic              primed_q, primed_d;
  logic [CNT_W-1:0]  hist_q [DEPTH];
  logic [CNT_W-1:0]  hist_d [DEPTH];
  // Average is kept separately because bin_q is consumed by the conversion shifts.
  logic [CNT_W-1:0]  avg_q, avg_d;
  logic [CNT_W-1:0]  bin_q, bin_d;
  logic [19:0]       bcd_q, bcd_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CNT_W-1:0]  out_avg_q, out_avg_d;
  logic [19:0]       out_bcd_q, out_bcd_d;
  logic              drop_q, drop_d;
`ifdef FREQ_MINMAX_EN
  logic [CNT_W-1:0]  min_q, min_d;
  logic [CNT_W-1:0]  max_q, max_d;
`endif

  logic [SUM_W-1:0]  sum_new;
  logic [19:0]       bcd_adj;
  logic [19:0]       bcd_step;
  logic [CNT_W-1:0]  bin_step;

  // Running sum after folding in the registered sample (first sample fills the whole window).
  always_comb begin
    if (!primed_q) begin
      sum_new = SUM_W'(sample_q) << AVG_LOG2;
    end else begin
      sum_new = sum_q - SUM_W'(hist_q[wp_q]) + SUM_W'(sample_q);
    end
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift the {bcd, bin} pair left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    {bcd_step, bin_step} = {bcd_adj, bin_q} << 1;
  end

  // FSM next state, history update, conversion datapath and clear handling.
  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    sum_d     = sum_q;
    wp_d      = wp_q;
    primed_d  = primed_q;
    hist_d    = hist_q;
    avg_d     = avg_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    step_d    = step_q;
    out_avg_d = out_avg_q;
    out_bcd_d = out_bcd_q;
`ifdef FREQ_MINMAX_EN
    min_d     = min_q;
    max_d     = max_q;
`endif
    drop_d    = in_vld && (state_q != IDLE) && !clr;

    case (state_q)
      IDLE: begin
        if (in_vld) begin
          sample_d = in_cnt;
          state_d  = ACC;
        end
      end
      ACC: begin
        sum_d    = sum_new;
        primed_d = 1'b1;
        if (!primed_q) begin
          for (int i = 0; i < DEPTH; i++) begin
            hist_d[i] = sample_q;
          end
        end else begin
          hist_d[wp_q] = sample_q;
          wp_d = (wp_q == WP_W'(DEPTH - 1)) ? '0 : wp_q + WP_W'(1);
        end
        avg_d   = sum_new[AVG_LOG2 +: CNT_W];
        bin_d   = sum_new[AVG_LOG2 +: CNT_W];
        bcd_d   = '0;
        step_d  = '0;
`ifdef FREQ_MINMAX_EN
        if (sample_q < min_q) min_d = sample_q;
        if (sample_q > max_q) max_d = sample_q;
`endif
        state_d = CONV;
      end
      CONV: begin
        bcd_d  = bcd_step;
        bin_d  = bin_step;
        step_d = step_q + STEP_W'(1);
        if (step_q == STEP_W'(CNT_W - 1)) begin
          out_avg_d = avg_q;
          out_bcd_d = bcd_step;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (clr) begin
      state_d   = IDLE;
      primed_d  = 1'b0;
      sum_d     = '0;
      wp_d      = '0;
      out_avg_d = '0;
      out_bcd_d = '0;
`ifdef FREQ_MINMAX_EN
      min_d     = '1;
      max_d     = '0;
`endif
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sample_q  <= '0;
      sum_q     <= '0;
      wp_q      <= '0;
      primed_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      avg_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      step_q    <= '0;
      out_avg_q <= '0;
      out_bcd_q <= '0;
      drop_q    <= 1'b0;
`ifdef FREQ_MINMAX_EN
      min_q     <= '1;
      max_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      sum_q     <= sum_d;
      wp_q      <= wp_d;
      primed_q  <= primed_d;
      hist_q    <= hist_d;
      avg_q     <= avg_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      step_q    <= step_d;
      out_avg_q <= out_avg_d;
      out_bcd_q <= out_bcd_d;
      drop_q    <= drop_d;
`ifdef FREQ_MINMAX_EN
      min_q     <= min_d;
      max_q     <= max_d;
`endif
    end
  end

  assign out_vld = (state_q == HOLD);
  assign busy    = (state_q != IDLE);
  assign drop    = drop_q;
  assign out_avg = out_avg_q;
  assign out_bcd = out_bcd_q;
`ifdef FREQ_MINMAX_EN
  assign out_min = min_q;
  assign out_max = max_q;
`endif

endmodule

// File: tb/tb_freq_avg_bcd.sv
// Bench for freq_avg_bcd: randomized samples checked against a queue-based window-average model.
module tb_freq_avg_bcd;
  localparam int CNT_W    = 16;
  localparam int AVG_LOG2 = 2;
  localparam int DEPTH    = 1 << AVG_LOG2;

  logic             clk;
  logic             rst;
  logic             clr;
  logic             in_vld;
  logic [CNT_W-1:0] in_cnt;
  logic             out_vld;
  logic             out_ready;
  logic [CNT_W-1:0] out_avg;
  logic [19:0]      out_bcd;
  logic             busy;
  logic             drop;
`ifdef FREQ_MINMAX_EN
  logic [CNT_W-1:0] out_min;
  logic [CNT_W-1:0] out_max;
`endif

  freq_avg_bcd #(.CNT_W(CNT_W), .AVG_LOG2(AVG_LOG2)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_vld    (in_vld),
    .in_cnt    (in_cnt),
    .out_vld   (out_vld),
    .out_ready (out_ready),
    .out_avg   (out_avg),
    .out_bcd   (out_bcd),
`ifdef FREQ_MINMAX_EN
    .out_min   (out_min),
    .out_max   (out_max),
`endif
    .busy      (busy),
    .drop      (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the last DEPTH accepted samples, plus min/max of raw samples.
  int unsigned hist[$];
  bit          primed;
  int unsigned mmin, mmax;

  function automatic void model_clear();
    hist.delete();
    primed = 1'b0;
    mmin   = 32'hFFFF;
    mmax   = 0;
  endfunction

  function automatic int unsigned model_accept(input int unsigned v);
    int unsigned s;
    if (!primed) begin
      hist.delete();
      for (int i = 0; i < DEPTH; i++) hist.push_back(v);
      primed = 1'b1;
    end else begin
      hist.push_back(v);
      void'(hist.pop_front());
    end
    if (v < mmin) mmin = v;
    if (v > mmax) mmax = v;
    s = 0;
    foreach (hist[i]) s += hist[i];
    return s / DEPTH;
  endfunction

  function automatic logic [19:0] bcd_of(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // inj bit0: strobe during CONV, bit1: strobe in first HOLD cycle, bit2: strobe on handshake cycle.
  task automatic do_sample(input int unsigned v, input int hold, input int inj);
    int n;
    int unsigned ea;
    in_vld = 1'b1;
    in_cnt = v[CNT_W-1:0];
    @(negedge clk);
    in_vld = 1'b0;
    ea = model_accept(v);
    check("busy_rise", busy, 1);
    n = 1;
    while (!out_vld && n < 40) begin
      if (inj[0] && n == 5) begin
        in_vld = 1'b1;
        in_cnt = CNT_W'($urandom);
      end
      @(negedge clk);
      n++;
      in_vld = 1'b0;
      if (inj[0] && n == 6) check("drop_conv", drop, 1);
      if (inj[0] && n == 7) check("drop_conv_len", drop, 0);
    end
    check("latency", n, CNT_W + 2);
    check("avg", out_avg, ea);
    check("bcd", out_bcd, bcd_of(ea));
`ifdef FREQ_MINMAX_EN
    check("min", out_min, mmin);
    check("max", out_max, mmax);
`endif
    for (int i = 0; i < hold; i++) begin
      if (inj[1] && i == 0) begin
        in_vld = 1'b1;
        in_cnt = CNT_W'($urandom);
      end
      @(negedge clk);
      in_vld = 1'b0;
      check("hold_vld", out_vld, 1);
      check("hold_avg", out_avg, ea);
      check("hold_bcd", out_bcd, bcd_of(ea));
      if (inj[1] && i == 0) check("drop_hold", drop, 1);
      if (inj[1] && i == 1) check("drop_hold_len", drop, 0);
    end
    out_ready = 1'b1;
    if (inj[2]) begin
      in_vld = 1'b1;
      in_cnt = CNT_W'($urandom);
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_vld    = 1'b0;
    check("vld_fall", out_vld, 0);
    check("busy_fall", busy, 0);
    if (inj[2]) check("drop_hs", drop, 1);
    else        check("no_drop", drop, 0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
  endtask

  initial begin
    int unsigned v;
    bit          ok;
    rst = 1'b1; clr = 1'b0; in_vld = 1'b0; in_cnt = '0; out_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_vld", out_vld, 0);
    check("rst_avg", out_avg, 0);
    check("rst_bcd", out_bcd, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop, 0);
`ifdef FREQ_MINMAX_EN
    check("rst_min", out_min, 32'hFFFF);
    check("rst_max", out_max, 0);
`endif

    // First sample after reset, held for 5 cycles before acceptance.
    do_sample(1000, 5, 0);

    // Window ramp.
    pulse_clr();
    for (int i = 1; i <= 5; i++) do_sample(100 * i, i % 2, 0);

    // Full-scale input must not wrap.
    for (int i = 0; i < 6; i++) do_sample(65535, 0, 0);

    // Dropped strobes must not reach the history.
    do_sample($urandom_range(0, 65535), 2, 3);
    do_sample($urandom_range(0, 65535), 0, 4);
    do_sample($urandom_range(0, 65535), 1, 0);

    // Clear in the middle of a conversion.
    in_vld = 1'b1;
    in_cnt = 16'd123;
    @(negedge clk);
    in_vld = 1'b0;
    repeat (5) @(negedge clk);
    pulse_clr();
    check("clr_busy", busy, 0);
    check("clr_vld", out_vld, 0);
    check("clr_avg", out_avg, 0);
    check("clr_bcd", out_bcd, 0);
`ifdef FREQ_MINMAX_EN
    check("clr_min", out_min, 32'hFFFF);
    check("clr_max", out_max, 0);
`endif
    ok = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (out_vld) ok = 1'b0;
    end
    check("clr_no_vld", ok, 1);
    do_sample(7, 0, 0);

    // Clear with a simultaneous strobe in IDLE: discarded, no drop.
    in_vld = 1'b1;
    in_cnt = 16'd999;
    clr    = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    clr    = 1'b0;
    model_clear();
    check("clr_in_drop", drop, 0);
    check("clr_in_busy", busy, 0);
    @(negedge clk);
    check("clr_in_busy2", busy, 0);

    // Asynchronous reset mid-conversion.
    in_vld = 1'b1;
    in_cnt = 16'd555;
    @(negedge clk);
    in_vld = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_vld", out_vld, 0);
    check("arst_avg", out_avg, 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    do_sample(42, 0, 0);

`ifdef FREQ_MINMAX_EN
    pulse_clr();
    do_sample(50, 0, 0);
    do_sample(10, 0, 0);
    do_sample(90, 0, 0);
    check("mm_min", out_min, 10);
    check("mm_max", out_max, 90);
    pulse_clr();
    check("mm_clr_min", out_min, 32'hFFFF);
    check("mm_clr_max", out_max, 0);
`endif

    // Randomized traffic with occasional clears.
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 9) == 0) pulse_clr();
      if ($urandom_range(0, 3) == 0) v = 65535 - $urandom_range(0, 20);
      else                           v = $urandom_range(0, 65535);
      do_sample(v, $urandom_range(0, 3), $urandom_range(0, 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
